mod_step_counter: RTL and testbench

//   Parametrised loadable up/down counter with programmable step and modulo limit.

---
 rtl/mod_step_counter.sv | 112 +++++++++++
 tb/tb_mod_step_counter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_step_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_step_counter
// Brief    : Loadable up/down counter, programmable step, modulo MAX_VALUE+1.
//            Optional macro SATURATE_EN clamps at 0/MAX_VALUE instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module mod_step_counter #(
    parameter int CNT_WIDTH  = 5,
    parameter int STEP_WIDTH = 3,
    parameter int MAX_VALUE  = 2**CNT_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  enab,
    input  logic                  up_dn,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [CNT_WIDTH-1:0]  cnt_in,
    output logic [CNT_WIDTH-1:0]  cnt_out,
    output logic                  wrap,
    output logic                  zero
);

    localparam int                 c_ext_w   = CNT_WIDTH + 1;
    localparam logic [CNT_WIDTH:0] c_max     = c_ext_w'(MAX_VALUE);
    localparam logic [CNT_WIDTH-1:0] c_max_cnt = CNT_WIDTH'(MAX_VALUE);
`ifndef SATURATE_EN
    localparam logic [CNT_WIDTH:0] c_mod     = c_ext_w'(MAX_VALUE + 1);
`endif

    // Reject configurations where the range or step cannot be represented
    if (CNT_WIDTH < 2) begin : g_chk_cnt_width
        $error("mod_step_counter: CNT_WIDTH must be >= 2");
    end
    if (STEP_WIDTH < 1 || STEP_WIDTH > CNT_WIDTH) begin : g_chk_step_width
        $error("mod_step_counter: STEP_WIDTH must be in 1..CNT_WIDTH");
    end
    if (MAX_VALUE > 2**CNT_WIDTH - 1) begin : g_chk_max_hi
        $error("mod_step_counter: MAX_VALUE exceeds counter width");
    end
    if (MAX_VALUE < 2**STEP_WIDTH - 1) begin : g_chk_max_lo
        $error("mod_step_counter: MAX_VALUE smaller than largest step");
    end

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_wrap;
    logic [CNT_WIDTH:0]   w_cnt_ext;
    logic [CNT_WIDTH:0]   w_step_ext;
    logic [CNT_WIDTH:0]   w_sum;
    logic                 w_up_over;
    logic                 w_dn_under;
    logic [CNT_WIDTH-1:0] w_load_val;
    logic [CNT_WIDTH-1:0] w_next_cnt;
    logic                 w_next_wrap;

    // Arithmetic is done one bit wider so the up-sum never overflows
    assign w_cnt_ext  = {1'b0, r_cnt};
    assign w_step_ext = {{(CNT_WIDTH + 1 - STEP_WIDTH){1'b0}}, step};
    assign w_sum      = w_cnt_ext + w_step_ext;
    assign w_up_over  = (w_sum > c_max);
    assign w_dn_under = (w_step_ext > w_cnt_ext);
    assign w_load_val = ({1'b0, cnt_in} > c_max) ? c_max_cnt : cnt_in;

    always_comb begin
        w_next_cnt  = r_cnt;
        w_next_wrap = 1'b0;
        if (load) begin
            w_next_cnt = w_load_val;
        end else if (enab) begin
            if (up_dn) begin
                if (w_up_over) begin
                    w_next_wrap = 1'b1;
`ifdef SATURATE_EN
                    w_next_cnt  = c_max_cnt;
`else
                    w_next_cnt  = CNT_WIDTH'(w_sum - c_mod);
`endif
                end else begin
                    w_next_cnt = CNT_WIDTH'(w_sum);
                end
            end else begin
                if (w_dn_under) begin
                    w_next_wrap = 1'b1;
`ifdef SATURATE_EN
                    w_next_cnt  = '0;
`else
                    w_next_cnt  = CNT_WIDTH'(w_cnt_ext + c_mod - w_step_ext);
`endif
                end else begin
                    w_next_cnt = CNT_WIDTH'(w_cnt_ext - w_step_ext);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_next_cnt;
            r_wrap <= w_next_wrap;
        end
    end

    assign cnt_out = r_cnt;
    assign wrap    = r_wrap;
    assign zero    = (r_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_mod_step_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_step_counter
// Brief    : Scoreboard bench for mod_step_counter (CNT_WIDTH=5, STEP_WIDTH=3,
//            MAX_VALUE=23). Honors SATURATE_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_step_counter;

    localparam int c_max = 23;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic       enab;
    logic       up_dn;
    logic [2:0] step;
    logic [4:0] cnt_in;
    logic [4:0] cnt_out;
    logic       wrap;
    logic       zero;

    typedef struct {
        logic [4:0] cnt;
        logic       wrap;
    } exp_t;

    typedef struct {
        logic       ld;
        logic       en;
        logic       ud;
        logic [2:0] st;
        logic [4:0] ci;
        logic [4:0] ecnt;
        logic       ew;
    } vec_t;

    exp_t q_exp[$];
    int   checks;
    int   errors;
    int   m_cnt;
    logic m_wrap;

    mod_step_counter #(
        .CNT_WIDTH  (5),
        .STEP_WIDTH (3),
        .MAX_VALUE  (c_max)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .enab    (enab),
        .up_dn   (up_dn),
        .step    (step),
        .cnt_in  (cnt_in),
        .cnt_out (cnt_out),
        .wrap    (wrap),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs and advances the reference model
    task automatic drive(input logic ld, input logic en, input logic ud,
                         input logic [2:0] st, input logic [4:0] ci);
        int s;
        load   = ld;
        enab   = en;
        up_dn  = ud;
        step   = st;
        cnt_in = ci;
        if (ld) begin
            m_cnt  = (int'(ci) > c_max) ? c_max : int'(ci);
            m_wrap = 1'b0;
        end else if (en) begin
            if (ud) begin
                s = m_cnt + int'(st);
                if (s > c_max) begin
`ifdef SATURATE_EN
                    m_cnt = c_max;
`else
                    m_cnt = s - (c_max + 1);
`endif
                    m_wrap = 1'b1;
                end else begin
                    m_cnt  = s;
                    m_wrap = 1'b0;
                end
            end else begin
                if (int'(st) > m_cnt) begin
`ifdef SATURATE_EN
                    m_cnt = 0;
`else
                    m_cnt = m_cnt + (c_max + 1) - int'(st);
`endif
                    m_wrap = 1'b1;
                end else begin
                    m_cnt  = m_cnt - int'(st);
                    m_wrap = 1'b0;
                end
            end
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 3'd0, 5'd0);
        m_cnt  = 0;
        m_wrap = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cnt_out !== 5'd0 || wrap !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset: cnt_out=%0d wrap=%0b zero=%0b, expected 0 0 1",
                     cnt_out, wrap, zero);
        end
        rst_n = 1'b1;
    endtask

`ifndef SATURATE_EN
    task automatic test_load();
        vec_t v[3];
        exp_t e;
        v[0] = '{1'b1, 1'b1, 1'b1, 3'd3, 5'd21, 5'd21, 1'b0};
        v[1] = '{1'b1, 1'b1, 1'b0, 3'd7, 5'd30, 5'd23, 1'b0};
        v[2] = '{1'b1, 1'b0, 1'b1, 3'd0, 5'd23, 5'd23, 1'b0};
        for (int i = 0; i < 3; i++) begin
            q_exp.push_back('{v[i].ecnt, v[i].ew});
            drive(v[i].ld, v[i].en, v[i].ud, v[i].st, v[i].ci);
            @(negedge clk);
            e = q_exp.pop_front();
            checks++;
            if (cnt_out !== e.cnt || wrap !== e.wrap || zero !== (e.cnt == 5'd0)) begin
                errors++;
                $display("FAIL load[%0d]: cnt_out=%0d wrap=%0b zero=%0b, expected %0d %0b %0b",
                         i, cnt_out, wrap, zero, e.cnt, e.wrap, (e.cnt == 5'd0));
            end
        end
    endtask

    task automatic test_up_wrap();
        vec_t v[4];
        exp_t e;
        v[0] = '{1'b1, 1'b0, 1'b1, 3'd0, 5'd21, 5'd21, 1'b0};
        v[1] = '{1'b0, 1'b1, 1'b1, 3'd3, 5'd0,  5'd0,  1'b1};
        v[2] = '{1'b0, 1'b1, 1'b1, 3'd3, 5'd9,  5'd3,  1'b0};
        v[3] = '{1'b0, 1'b1, 1'b1, 3'd0, 5'd9,  5'd3,  1'b0};
        for (int i = 0; i < 4; i++) begin
            q_exp.push_back('{v[i].ecnt, v[i].ew});
            drive(v[i].ld, v[i].en, v[i].ud, v[i].st, v[i].ci);
            @(negedge clk);
            e = q_exp.pop_front();
            checks++;
            if (cnt_out !== e.cnt || wrap !== e.wrap || zero !== (e.cnt == 5'd0)) begin
                errors++;
                $display("FAIL up_wrap[%0d]: cnt_out=%0d wrap=%0b zero=%0b, expected %0d %0b %0b",
                         i, cnt_out, wrap, zero, e.cnt, e.wrap, (e.cnt == 5'd0));
            end
        end
    endtask

    task automatic test_down_wrap();
        vec_t v[3];
        exp_t e;
        v[0] = '{1'b0, 1'b1, 1'b0, 3'd5, 5'd0, 5'd22, 1'b1};
        v[1] = '{1'b0, 1'b1, 1'b0, 3'd7, 5'd0, 5'd15, 1'b0};
        v[2] = '{1'b0, 1'b0, 1'b0, 3'd7, 5'd0, 5'd15, 1'b0};
        for (int i = 0; i < 3; i++) begin
            q_exp.push_back('{v[i].ecnt, v[i].ew});
            drive(v[i].ld, v[i].en, v[i].ud, v[i].st, v[i].ci);
            @(negedge clk);
            e = q_exp.pop_front();
            checks++;
            if (cnt_out !== e.cnt || wrap !== e.wrap || zero !== (e.cnt == 5'd0)) begin
                errors++;
                $display("FAIL down_wrap[%0d]: cnt_out=%0d wrap=%0b zero=%0b, expected %0d %0b %0b",
                         i, cnt_out, wrap, zero, e.cnt, e.wrap, (e.cnt == 5'd0));
            end
        end
    endtask

    // Exact landings on the limits, and wrap cleared by hold and by load
    task automatic test_boundary();
        vec_t v[8];
        exp_t e;
        v[0] = '{1'b1, 1'b0, 1'b1, 3'd0, 5'd20, 5'd20, 1'b0};
        v[1] = '{1'b0, 1'b1, 1'b1, 3'd3, 5'd0,  5'd23, 1'b0};
        v[2] = '{1'b1, 1'b0, 1'b0, 3'd0, 5'd3,  5'd3,  1'b0};
        v[3] = '{1'b0, 1'b1, 1'b0, 3'd3, 5'd0,  5'd0,  1'b0};
        v[4] = '{1'b0, 1'b1, 1'b0, 3'd1, 5'd0,  5'd23, 1'b1};
        v[5] = '{1'b0, 1'b0, 1'b1, 3'd1, 5'd0,  5'd23, 1'b0};
        v[6] = '{1'b0, 1'b1, 1'b1, 3'd1, 5'd0,  5'd0,  1'b1};
        v[7] = '{1'b1, 1'b1, 1'b1, 3'd7, 5'd5,  5'd5,  1'b0};
        for (int i = 0; i < 8; i++) begin
            q_exp.push_back('{v[i].ecnt, v[i].ew});
            drive(v[i].ld, v[i].en, v[i].ud, v[i].st, v[i].ci);
            @(negedge clk);
            e = q_exp.pop_front();
            checks++;
            if (cnt_out !== e.cnt || wrap !== e.wrap || zero !== (e.cnt == 5'd0)) begin
                errors++;
                $display("FAIL boundary[%0d]: cnt_out=%0d wrap=%0b zero=%0b, expected %0d %0b %0b",
                         i, cnt_out, wrap, zero, e.cnt, e.wrap, (e.cnt == 5'd0));
            end
        end
    endtask
`else
    task automatic test_saturate();
        vec_t v[7];
        exp_t e;
        v[0] = '{1'b1, 1'b0, 1'b1, 3'd0, 5'd22, 5'd22, 1'b0};
        v[1] = '{1'b0, 1'b1, 1'b1, 3'd3, 5'd0,  5'd23, 1'b1};
        v[2] = '{1'b0, 1'b1, 1'b1, 3'd3, 5'd0,  5'd23, 1'b1};
        v[3] = '{1'b1, 1'b1, 1'b1, 3'd3, 5'd30, 5'd23, 1'b0};
        v[4] = '{1'b1, 1'b0, 1'b0, 3'd0, 5'd4,  5'd4,  1'b0};
        v[5] = '{1'b0, 1'b1, 1'b0, 3'd7, 5'd0,  5'd0,  1'b1};
        v[6] = '{1'b0, 1'b0, 1'b0, 3'd7, 5'd0,  5'd0,  1'b0};
        for (int i = 0; i < 7; i++) begin
            q_exp.push_back('{v[i].ecnt, v[i].ew});
            drive(v[i].ld, v[i].en, v[i].ud, v[i].st, v[i].ci);
            @(negedge clk);
            e = q_exp.pop_front();
            checks++;
            if (cnt_out !== e.cnt || wrap !== e.wrap || zero !== (e.cnt == 5'd0)) begin
                errors++;
                $display("FAIL saturate[%0d]: cnt_out=%0d wrap=%0b zero=%0b, expected %0d %0b %0b",
                         i, cnt_out, wrap, zero, e.cnt, e.wrap, (e.cnt == 5'd0));
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 31)));
            q_exp.push_back('{5'(m_cnt), m_wrap});
            @(negedge clk);
            e = q_exp.pop_front();
            checks++;
            if (cnt_out !== e.cnt || wrap !== e.wrap || zero !== (e.cnt == 5'd0)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: cnt_out=%0d wrap=%0b zero=%0b, expected %0d %0b %0b",
                         i, cnt_out, wrap, zero, e.cnt, e.wrap, (e.cnt == 5'd0));
            end
        end
    endtask

    // Reset asserted between edges while counting, held across an edge, then released
    task automatic test_reset_mid();
        exp_t e;
        drive(1'b1, 1'b0, 1'b1, 3'd0, 5'd10);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 3'd2, 5'd0);
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        m_cnt  = 0;
        m_wrap = 1'b0;
        #1;
        checks++;
        if (cnt_out !== 5'd0 || wrap !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: cnt_out=%0d wrap=%0b zero=%0b, expected 0 0 1",
                     cnt_out, wrap, zero);
        end
        @(negedge clk);
        checks++;
        if (cnt_out !== 5'd0 || wrap !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_held: cnt_out=%0d wrap=%0b zero=%0b, expected 0 0 1",
                     cnt_out, wrap, zero);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 3'd2, 5'd0);
        q_exp.push_back('{5'(m_cnt), m_wrap});
        @(negedge clk);
        e = q_exp.pop_front();
        checks++;
        if (cnt_out !== e.cnt || wrap !== e.wrap || zero !== (e.cnt == 5'd0)) begin
            errors++;
            $display("FAIL reset_release: cnt_out=%0d wrap=%0b zero=%0b, expected %0d %0b %0b",
                     cnt_out, wrap, zero, e.cnt, e.wrap, (e.cnt == 5'd0));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
`ifndef SATURATE_EN
        test_load();
        test_up_wrap();
        test_down_wrap();
        test_boundary();
`else
        test_saturate();
`endif
        test_back_to_back();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
